// File: rtl/cache_core_assoc.sv
// cache_core_assoc
// N-way set-associative storage and lookup core. Lookup is combinational,
// and all state changes happen on the rising edge of CLK.
// Replacement is per-set LRU. The core reports the victim way for write-back.
// A flush engine walks every line and presents each dirty block on a
// ready/valid port.
module cache_core_assoc #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 32,
  parameter int BBITS = 5,
  parameter int IBITS = 8,
  parameter int WAYS  = 2,
  parameter int TBITS = ASIZE - IBITS - BBITS,
  parameter int BSIZE = 8 << BBITS
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SYS,
  input  logic             dread,
  input  logic             dwrite,
  input  logic [1:0]       dwmode,
  input  logic             bwrite,
  input  logic [ASIZE-1:0] address,
  input  logic [DSIZE-1:0] data_in,
  input  logic [BSIZE-1:0] block_in,
  output logic [DSIZE-1:0] data_out,
  output logic [BSIZE-1:0] block_out,
  output logic             hit,
  output logic             victim_dirty,
  output logic [TBITS-1:0] victim_tag,
  input  logic             flush_start,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [ASIZE-1:0] wb_addr,
  output logic [BSIZE-1:0] wb_block
);

  localparam int SETS   = 1 << IBITS;
  // Width of the way index and of the LRU age. It is kept at 1 bit for a
  // direct-mapped build.
  localparam int WBITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int NWORDS = BSIZE / DSIZE;
  localparam int OBITS  = BBITS - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } flush_state_t;

  // Per-line status bits. These are the only arrays that are reset.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WBITS-1:0] age_q   [SETS][WAYS];

  // Tag and data storage.
  logic [TBITS-1:0] tag_mem [SETS][WAYS];
  logic [BSIZE-1:0] blk_mem [SETS][WAYS];

  // Address fields.
  logic [TBITS-1:0] a_tag;
  logic [IBITS-1:0] a_set;
  logic [OBITS-1:0] a_word;
  logic [1:0]       a_lane;

  assign a_tag  = address[ASIZE-1 -: TBITS];
  assign a_set  = address[BBITS +: IBITS];
  assign a_word = address[2 +: OBITS];
  assign a_lane = address[1:0];

  // Lookup, victim and flush signals.
  logic [WAYS-1:0]  hit_vec;
  logic [WBITS-1:0] hit_way;
  logic [WBITS-1:0] vic_way;
  logic [WBITS-1:0] vic_age;
  logic             vic_found_inv;
  logic [BSIZE-1:0] hit_blk;
  logic [BSIZE-1:0] st_blk;
  logic [DSIZE-1:0] st_word;
  logic             busy;
  logic             do_store;
  logic             do_fill;
  logic             do_touch;
  logic [WBITS-1:0] touch_way;
  logic [WBITS-1:0] touch_old;

  flush_state_t     state_q, state_d;
  logic [IBITS-1:0] ptr_set;
  logic [WBITS-1:0] ptr_way;
  logic             ptr_last;
  logic             ptr_line_dirty;
  logic             ptr_clear;
  logic             ptr_adv;
  logic             wb_clear;

  assign busy = (state_q != S_IDLE);

  // Tag compare across the ways of the addressed set, then encode the hit way.
  // NOTE: every variable written in an always_comb gets a default first. A
  // path that leaves a variable unassigned would infer a latch.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[a_set][w] && (tag_mem[a_set][w] == a_tag);
      if (hit_vec[w]) hit_way = WBITS'(w);
    end
  end

  // A running flush hides every line from lookups.
  assign hit = (|hit_vec) && !busy;

  // Victim choice: the lowest invalid way if there is one. Otherwise the
  // oldest way, with ties going to the lower index.
  always_comb begin
    vic_way       = '0;
    vic_age       = '0;
    vic_found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found_inv && !valid_q[a_set][w]) begin
        vic_found_inv = 1'b1;
        vic_way       = WBITS'(w);
      end
    end
    if (!vic_found_inv) begin
      vic_age = age_q[a_set][0];
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[a_set][w] > vic_age) begin
          vic_age = age_q[a_set][w];
          vic_way = WBITS'(w);
        end
      end
    end
  end

  assign victim_dirty = valid_q[a_set][vic_way] && dirty_q[a_set][vic_way];
  assign victim_tag   = tag_mem[a_set][vic_way];

  // Read path. Words are big-endian: word 0 sits in the block MSBs.
  assign hit_blk   = blk_mem[a_set][hit_way];
  assign data_out  = hit_blk[(NWORDS - 1 - int'(a_word)) * DSIZE +: DSIZE];
  assign block_out = hit ? hit_blk : blk_mem[a_set][vic_way];

  // Merge the store data into the hit word. Byte lane 0 and half 0 are the MSBs.
  always_comb begin
    st_word = data_out;
    case (dwmode)
      2'b01:   st_word[(3 - int'(a_lane)) * 8 +: 8]      = data_in[7:0];
      2'b10:   st_word[(1 - int'(a_lane[1])) * 16 +: 16] = data_in[15:0];
      default: st_word                                   = data_in;
    endcase
    st_blk = hit_blk;
    st_blk[(NWORDS - 1 - int'(a_word)) * DSIZE +: DSIZE] = st_word;
  end

  // When a store and a fill arrive together, the store wins and the fill is
  // dropped. A running flush blocks both.
  assign do_store  = dwrite && hit;
  assign do_fill   = bwrite && !do_store && !busy;
  assign do_touch  = (dread && hit) || do_store || do_fill;
  assign touch_way = do_fill ? vic_way : hit_way;
  // All ages are 0 after a reset. Treating an invalid way as the oldest when it
  // is filled keeps the ages of a set a permutation as the set fills. It also
  // keeps increments below WAYS-1.
  assign touch_old = valid_q[a_set][touch_way] ? age_q[a_set][touch_way]
                                                : WBITS'(WAYS - 1);

  // Line status: valid, dirty and LRU age. Cleared by reset and by SYS.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff block reads the values from before the edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else if (SYS) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      if (do_store) dirty_q[a_set][hit_way] <= 1'b1;
      if (do_fill) begin
        valid_q[a_set][vic_way] <= 1'b1;
        dirty_q[a_set][vic_way] <= 1'b0;
      end
      if (do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WBITS'(w) == touch_way)
            age_q[a_set][w] <= '0;
          else if (age_q[a_set][w] < touch_old)
            age_q[a_set][w] <= age_q[a_set][w] + 1'b1;
        end
      end
      if (wb_clear) dirty_q[ptr_set][ptr_way] <= 1'b0;
    end
  end

  // Tag and block storage writes for stores and fills.
  // NOTE: tag and data arrays are not reset. The valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge CLK) begin
    if (do_store) blk_mem[a_set][hit_way] <= st_blk;
    if (do_fill) begin
      tag_mem[a_set][vic_way] <= a_tag;
      blk_mem[a_set][vic_way] <= block_in;
    end
  end

  // Flush pointer status.
  assign ptr_last       = (ptr_set == IBITS'(SETS - 1)) && (ptr_way == WBITS'(WAYS - 1));
  assign ptr_line_dirty = valid_q[ptr_set][ptr_way] && dirty_q[ptr_set][ptr_way];

  // Flush next-state logic and pointer control.
  always_comb begin
    state_d   = state_q;
    ptr_clear = 1'b0;
    ptr_adv   = 1'b0;
    wb_clear  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_start) begin
          state_d   = S_SCAN;
          ptr_clear = 1'b1;
        end
      end
      S_SCAN: begin
        if (ptr_line_dirty)
          state_d = S_EMIT;
        else if (ptr_last)
          state_d = S_DONE;
        else
          ptr_adv = 1'b1;
      end
      S_EMIT: begin
        if (wb_ready) begin
          wb_clear = 1'b1;
          if (ptr_last) begin
            state_d = S_DONE;
          end else begin
            ptr_adv = 1'b1;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flush state register and line pointer. The way index is the inner loop.
  // SYS aborts a flush immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ptr_set <= '0;
      ptr_way <= '0;
    end else if (SYS) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
      if (ptr_clear) begin
        ptr_set <= '0;
        ptr_way <= '0;
      end else if (ptr_adv) begin
        if (ptr_way == WBITS'(WAYS - 1)) begin
          ptr_way <= '0;
          ptr_set <= ptr_set + 1'b1;
        end else begin
          ptr_way <= ptr_way + 1'b1;
        end
      end
    end
  end

  assign flush_busy = busy;
  assign flush_done = (state_q == S_DONE);
  assign wb_valid   = (state_q == S_EMIT);
  assign wb_addr    = {tag_mem[ptr_set][ptr_way], ptr_set, {BBITS{1'b0}}};
  assign wb_block   = blk_mem[ptr_set][ptr_way];

endmodule

// File: tb/tb_cache_core_assoc.sv
// tb_cache_core_assoc
// Table-driven bench for cache_core_assoc with the default parameters
// (2 ways, 256 sets, 32-byte blocks), plus hand-written flush, SYS and
// reset sequences.
module tb_cache_core_assoc;

  localparam int ASIZE = 32;
  localparam int DSIZE = 32;
  localparam int BSIZE = 256;
  localparam int TBITS = 19;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             SYS = 1'b0;
  logic             dread = 1'b0;
  logic             dwrite = 1'b0;
  logic [1:0]       dwmode = 2'b00;
  logic             bwrite = 1'b0;
  logic [ASIZE-1:0] address = '0;
  logic [DSIZE-1:0] data_in = '0;
  logic [BSIZE-1:0] block_in = '0;
  logic [DSIZE-1:0] data_out;
  logic [BSIZE-1:0] block_out;
  logic             hit;
  logic             victim_dirty;
  logic [TBITS-1:0] victim_tag;
  logic             flush_start = 1'b0;
  logic             flush_busy;
  logic             flush_done;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [ASIZE-1:0] wb_addr;
  logic [BSIZE-1:0] wb_block;

  cache_core_assoc dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SYS          (SYS),
    .dread        (dread),
    .dwrite       (dwrite),
    .dwmode       (dwmode),
    .bwrite       (bwrite),
    .address      (address),
    .data_in      (data_in),
    .block_in     (block_in),
    .data_out     (data_out),
    .block_out    (block_out),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .flush_start  (flush_start),
    .flush_busy   (flush_busy),
    .flush_done   (flush_done),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_block     (wb_block)
  );

  always #5 CLK = ~CLK;

  // At most one way of a set may match the tag.
  always @(negedge CLK) begin
    if (!RESET) assert ($countones(dut.hit_vec) <= 1) else $error("multiple ways hit at 0x%0h", address);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [BSIZE-1:0] act, input logic [BSIZE-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string            name;
    logic             rd;
    logic             wr;
    logic [1:0]       mode;
    logic             fill;
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] din;
    logic [BSIZE-1:0] blk;
    logic             exp_hit;
    logic             chk_data;
    logic [DSIZE-1:0] exp_data;
    logic             chk_vic;
    logic             exp_vd;
    logic [TBITS-1:0] exp_vt;
    logic             chk_blk;
    logic [BSIZE-1:0] exp_blk;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rd, input logic wr, input logic [1:0] mode,
                              input logic fill, input logic [ASIZE-1:0] addr, input logic [DSIZE-1:0] din,
                              input logic [BSIZE-1:0] blk, input logic eh, input logic cd,
                              input logic [DSIZE-1:0] ed, input logic cv, input logic evd,
                              input logic [TBITS-1:0] evt, input logic cb, input logic [BSIZE-1:0] eb);
    vec_t t;
    t.name = name; t.rd = rd; t.wr = wr; t.mode = mode; t.fill = fill;
    t.addr = addr; t.din = din; t.blk = blk; t.exp_hit = eh;
    t.chk_data = cd; t.exp_data = ed; t.chk_vic = cv; t.exp_vd = evd; t.exp_vt = evt;
    t.chk_blk = cb; t.exp_blk = eb;
    return t;
  endfunction

  // Drive one vector at the falling edge and compare the combinational view
  // before the next rising edge commits it.
  task automatic apply(input vec_t t);
    @(negedge CLK);
    dread = t.rd; dwrite = t.wr; dwmode = t.mode; bwrite = t.fill;
    address = t.addr; data_in = t.din; block_in = t.blk;
    #1;
    check({t.name, ".hit"}, BSIZE'(hit), BSIZE'(t.exp_hit));
    if (t.chk_data) check({t.name, ".data_out"}, BSIZE'(data_out), BSIZE'(t.exp_data));
    if (t.chk_vic) begin
      check({t.name, ".victim_dirty"}, BSIZE'(victim_dirty), BSIZE'(t.exp_vd));
      check({t.name, ".victim_tag"}, BSIZE'(victim_tag), BSIZE'(t.exp_vt));
    end
    if (t.chk_blk) check({t.name, ".block_out"}, block_out, t.exp_blk);
  endtask

  task automatic idle(input logic [ASIZE-1:0] addr);
    @(negedge CLK);
    dread = 1'b0; dwrite = 1'b0; bwrite = 1'b0; dwmode = 2'b00; address = addr;
  endtask

  localparam logic [ASIZE-1:0] A = 32'h0000_1000;
  localparam logic [ASIZE-1:0] B = 32'h0010_1000;
  localparam logic [ASIZE-1:0] C = 32'h0020_1000;
  localparam logic [ASIZE-1:0] D = 32'h0030_1000;
  localparam logic [TBITS-1:0] TA = 19'h0;
  localparam logic [TBITS-1:0] TB = 19'h80;
  localparam logic [TBITS-1:0] TC = 19'h100;

  logic [ASIZE-1:0] exp_wb_addr [2];
  logic [BSIZE-1:0] exp_wb_blk  [2];

  // Run one flush. The first emitted block is stalled for 'hold' cycles.
  // Checks the emitted blocks, the scan/emit cycle count and a single
  // done pulse.
  task automatic flush_run(input string tag, input int hold, input int exp_emits, input int exp_cnt);
    int cnt, emits, stall;
    logic done;
    logic [ASIZE-1:0] a0;
    logic [BSIZE-1:0] b0;
    cnt = 0; emits = 0; stall = 0; done = 1'b0; a0 = '0; b0 = '0;
    @(negedge CLK);
    flush_start = 1'b1; wb_ready = 1'b0;
    @(negedge CLK);
    flush_start = 1'b0;
    check({tag, ".busy"}, BSIZE'(flush_busy), BSIZE'(1'b1));
    check({tag, ".hit_forced_low"}, BSIZE'(hit), BSIZE'(1'b0));
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      if (flush_done) begin
        done = 1'b1;
      end else begin
        if (flush_busy) cnt++;
        wb_ready = 1'b0;
        if (wb_valid) begin
          if (emits == 0 && stall == 0) begin
            a0 = wb_addr;
            b0 = wb_block;
          end
          if (emits == 0 && stall < hold) begin
            if (stall > 0) begin
              check({tag, ".stall_addr_stable"}, BSIZE'(wb_addr), BSIZE'(a0));
              check({tag, ".stall_block_stable"}, wb_block, b0);
            end
            stall++;
          end else begin
            if (emits == 0 && hold > 0) check({tag, ".accept_addr_stable"}, BSIZE'(wb_addr), BSIZE'(a0));
            if (emits < exp_emits && emits < 2) begin
              check($sformatf("%s.wb_addr%0d", tag, emits), BSIZE'(wb_addr), BSIZE'(exp_wb_addr[emits]));
              check($sformatf("%s.wb_block%0d", tag, emits), wb_block, exp_wb_blk[emits]);
            end else begin
              check({tag, ".unexpected_emit"}, BSIZE'(wb_valid), BSIZE'(1'b0));
            end
            emits++;
            wb_ready = 1'b1;
          end
        end
        @(negedge CLK);
      end
    end
    wb_ready = 1'b0;
    check({tag, ".done_seen"}, BSIZE'(done), BSIZE'(1'b1));
    check({tag, ".scan_emit_cycles"}, BSIZE'(cnt), BSIZE'(exp_cnt));
    check({tag, ".emits"}, BSIZE'(emits), BSIZE'(exp_emits));
    @(negedge CLK);
    check({tag, ".done_single_pulse"}, BSIZE'(flush_done), BSIZE'(1'b0));
    check({tag, ".idle_after"}, BSIZE'(flush_busy), BSIZE'(1'b0));
  endtask

  // Start a flush with wb_ready low and wait for the first emitted block.
  task automatic start_and_wait_emit(input string tag);
    logic seen;
    seen = 1'b0;
    @(negedge CLK);
    flush_start = 1'b1; wb_ready = 1'b0;
    @(negedge CLK);
    flush_start = 1'b0;
    for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
      if (wb_valid) seen = 1'b1;
      else @(negedge CLK);
    end
    check({tag, ".emit_reached"}, BSIZE'(seen), BSIZE'(1'b1));
  endtask

  vec_t tv [$];
  vec_t sv [$];
  logic [BSIZE-1:0] zero_blk;
  logic [BSIZE-1:0] ones_blk;
  logic [BSIZE-1:0] a_blk;
  logic [BSIZE-1:0] c_blk;
  logic             done_seen;

  initial begin
    zero_blk = '0;
    ones_blk = '1;
    a_blk = '0;
    a_blk[223:192] = 32'h00AB_BEEF;
    a_blk[127:96]  = 32'h1234_5678;
    c_blk = '0;
    c_blk[255:224] = 32'hCAFE_F00D;
    exp_wb_addr[0] = A;
    exp_wb_addr[1] = B;
    exp_wb_blk[0] = '0;
    exp_wb_blk[0][255:224] = 32'hA0A0_A0A0;
    exp_wb_blk[1] = '0;
    exp_wb_blk[1][255:224] = 32'h0B0B_0B0B;

    //           name             rd wr mode  fl addr      din            blk       hit cd data           cv vd vt  cb exp_blk
    tv.push_back(mk("fill_A",       0, 0, 2'b00, 1, A,        32'h0,        zero_blk, 0, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("fill_B",       0, 0, 2'b00, 1, B,        32'h0,        zero_blk, 0, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("look_A",       0, 0, 2'b00, 0, A,        32'h0,        zero_blk, 1, 1, 32'h0,         1, 0, TA, 0, zero_blk));
    tv.push_back(mk("look_B",       0, 0, 2'b00, 0, B,        32'h0,        zero_blk, 1, 1, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("read_A",       1, 0, 2'b00, 0, A,        32'h0,        zero_blk, 1, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("look_B_lru",   0, 0, 2'b00, 0, B,        32'h0,        zero_blk, 1, 0, 32'h0,         1, 0, TB, 0, zero_blk));
    tv.push_back(mk("fill_C",       0, 0, 2'b00, 1, C,        32'h0,        zero_blk, 0, 0, 32'h0,         1, 0, TB, 0, zero_blk));
    tv.push_back(mk("look_A_kept",  0, 0, 2'b00, 0, A,        32'h0,        zero_blk, 1, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("look_B_gone",  0, 0, 2'b00, 0, B,        32'h0,        zero_blk, 0, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("look_C",       0, 0, 2'b00, 0, C,        32'h0,        zero_blk, 1, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("st_byte",      0, 1, 2'b01, 0, A + 5,    32'hFFFF_FFAB, zero_blk, 1, 0, 32'h0,        0, 0, TA, 0, zero_blk));
    tv.push_back(mk("st_half",      0, 1, 2'b10, 0, A + 6,    32'h1234_BEEF, zero_blk, 1, 0, 32'h0,        0, 0, TA, 0, zero_blk));
    tv.push_back(mk("st_word",      0, 1, 2'b11, 0, A + 16,   32'h1234_5678, zero_blk, 1, 0, 32'h0,        0, 0, TA, 0, zero_blk));
    tv.push_back(mk("rd_w1",        0, 0, 2'b00, 0, A + 4,    32'h0,        zero_blk, 1, 1, 32'h00AB_BEEF, 1, 0, TC, 0, zero_blk));
    tv.push_back(mk("rd_w4",        0, 0, 2'b00, 0, A + 16,   32'h0,        zero_blk, 1, 1, 32'h1234_5678, 0, 0, TA, 0, zero_blk));
    tv.push_back(mk("rd_w4_lsb",    0, 0, 2'b00, 0, A + 19,   32'h0,        zero_blk, 1, 1, 32'h1234_5678, 0, 0, TA, 0, zero_blk));
    tv.push_back(mk("rd_w0",        0, 0, 2'b00, 0, A,        32'h0,        zero_blk, 1, 1, 32'h0,         0, 0, TA, 0, zero_blk));
    tv.push_back(mk("read_C",       1, 0, 2'b00, 0, C,        32'h0,        zero_blk, 1, 1, 32'h0,         1, 0, TC, 0, zero_blk));
    tv.push_back(mk("miss_D",       0, 0, 2'b00, 0, D,        32'h0,        zero_blk, 0, 0, 32'h0,         1, 1, TA, 1, a_blk));
    tv.push_back(mk("st_miss_D",    0, 1, 2'b11, 0, D,        32'hDEAD_BEEF, zero_blk, 0, 0, 32'h0,        0, 0, TA, 0, zero_blk));
    tv.push_back(mk("look_D",       0, 0, 2'b00, 0, D,        32'h0,        zero_blk, 0, 0, 32'h0,         1, 1, TA, 1, a_blk));
    tv.push_back(mk("st_C_and_fill",0, 1, 2'b00, 1, C,        32'hCAFE_F00D, ones_blk, 1, 0, 32'h0,        0, 0, TA, 0, zero_blk));
    tv.push_back(mk("look_C_st",    0, 0, 2'b00, 0, C,        32'h0,        zero_blk, 1, 1, 32'hCAFE_F00D, 0, 0, TA, 1, c_blk));
    tv.push_back(mk("look_A_after", 0, 0, 2'b00, 0, A + 16,   32'h0,        zero_blk, 1, 1, 32'h1234_5678, 1, 1, TA, 0, zero_blk));

    // Setup for the flush tests: two dirty lines, A in way 0 and B in way 1.
    sv.push_back(mk("fl_fill_A",    0, 0, 2'b00, 1, A,        32'h0,        zero_blk, 0, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    sv.push_back(mk("fl_fill_B",    0, 0, 2'b00, 1, B,        32'h0,        zero_blk, 0, 0, 32'h0,         0, 0, TA, 0, zero_blk));
    sv.push_back(mk("fl_st_A",      0, 1, 2'b00, 0, A,        32'hA0A0_A0A0, zero_blk, 1, 0, 32'h0,        0, 0, TA, 0, zero_blk));
    sv.push_back(mk("fl_st_B",      0, 1, 2'b00, 0, B,        32'h0B0B_0B0B, zero_blk, 1, 0, 32'h0,        0, 0, TA, 0, zero_blk));

    // Reset state.
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst.hit", BSIZE'(hit), BSIZE'(1'b0));
    check("rst.flush_busy", BSIZE'(flush_busy), BSIZE'(1'b0));
    check("rst.flush_done", BSIZE'(flush_done), BSIZE'(1'b0));
    check("rst.wb_valid", BSIZE'(wb_valid), BSIZE'(1'b0));

    foreach (tv[i]) apply(tv[i]);
    idle(A);

    // SYS invalidates everything in one cycle.
    @(negedge CLK);
    SYS = 1'b1;
    @(negedge CLK);
    SYS = 1'b0;
    address = A; #1;
    check("sys.hit_A", BSIZE'(hit), BSIZE'(1'b0));
    address = C; #1;
    check("sys.hit_C", BSIZE'(hit), BSIZE'(1'b0));

    foreach (sv[i]) apply(sv[i]);
    idle(A);

    // Flush with a 3-cycle stall on the first block: 512 line scans, 2 emits, 3 stalls.
    flush_run("flush1", 3, 2, 2 * 256 + 2 + 3);
    address = A; #1;
    check("post_flush.hit_A", BSIZE'(hit), BSIZE'(1'b1));
    check("post_flush.victim_clean", BSIZE'(victim_dirty), BSIZE'(1'b0));

    // A second flush finds nothing dirty.
    flush_run("flush2", 0, 0, 2 * 256);

    // SYS in the middle of an emit aborts with no done pulse.
    apply(mk("sa_st_A", 0, 1, 2'b00, 0, A, 32'hA0A0_A0A0, zero_blk, 1, 0, 32'h0, 0, 0, TA, 0, zero_blk));
    idle(A);
    start_and_wait_emit("sys_abort");
    SYS = 1'b1;
    @(negedge CLK);
    SYS = 1'b0;
    #1;
    check("sys_abort.busy", BSIZE'(flush_busy), BSIZE'(1'b0));
    check("sys_abort.wb_valid", BSIZE'(wb_valid), BSIZE'(1'b0));
    address = A; #1;
    check("sys_abort.hit_A", BSIZE'(hit), BSIZE'(1'b0));
    address = B; #1;
    check("sys_abort.hit_B", BSIZE'(hit), BSIZE'(1'b0));
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge CLK);
      if (flush_done) done_seen = 1'b1;
    end
    check("sys_abort.no_done", BSIZE'(done_seen), BSIZE'(1'b0));

    // Asynchronous reset between clock edges while a block is presented.
    apply(mk("rs_fill_A", 0, 0, 2'b00, 1, A, 32'h0, zero_blk, 0, 0, 32'h0, 0, 0, TA, 0, zero_blk));
    apply(mk("rs_st_A", 0, 1, 2'b00, 0, A, 32'h5555_AAAA, zero_blk, 1, 0, 32'h0, 0, 0, TA, 0, zero_blk));
    apply(mk("rs_look_A", 0, 0, 2'b00, 0, A, 32'h0, zero_blk, 1, 1, 32'h5555_AAAA, 0, 0, TA, 0, zero_blk));
    idle(A);
    start_and_wait_emit("async_rst");
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst.hit", BSIZE'(hit), BSIZE'(1'b0));
    check("async_rst.wb_valid", BSIZE'(wb_valid), BSIZE'(1'b0));
    check("async_rst.busy", BSIZE'(flush_busy), BSIZE'(1'b0));
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    #1;
    check("async_rst.idle_after", BSIZE'(flush_busy), BSIZE'(1'b0));
    check("async_rst.hit_A_invalid", BSIZE'(hit), BSIZE'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
